// File: rtl/branch_resolve_predict.sv
// Branch resolution unit with a BHT of 2-bit saturating counters: ID-side prediction, EX-side resolution and training.
// Optional macro PERF_CNT_EN enables the branch/mispredict performance counters.
module branch_resolve_predict #(
   parameter int XLEN        = 32,
   parameter int BHT_ENTRIES = 64,
   parameter int INDEX_LSB   = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] id_pc,
   output logic            id_pred_taken,
   input  logic            ex_valid,
   input  logic [XLEN-1:0] ex_pc,
   input  logic            ex_branch,
   input  logic            ex_jump,
   input  logic            ex_jalr,
   input  logic [2:0]      ex_branch_type,
   input  logic            ex_zero,
   input  logic            ex_slt,
   input  logic            ex_sltu,
   input  logic            ex_pred_taken,
   output logic [1:0]      pc_src,
   output logic            flush,
   output logic [31:0]     branch_count,
   output logic [31:0]     mispredict_count
);

   localparam int IDX_W = $clog2(BHT_ENTRIES);

   logic [1:0]       bht_q [BHT_ENTRIES];
   logic [1:0]       bht_d [BHT_ENTRIES];
   logic [IDX_W-1:0] id_idx;
   logic [IDX_W-1:0] ex_idx;
   logic             taken;
   logic             train;
   logic             unused_pc_bits;

   assign id_idx         = id_pc[INDEX_LSB +: IDX_W];
   assign ex_idx         = ex_pc[INDEX_LSB +: IDX_W];
   assign unused_pc_bits = ^{id_pc, ex_pc};
   // No bypass: a same-cycle lookup sees the counter before this edge's update.
   assign id_pred_taken  = bht_q[id_idx][1];

   // A jump flag in the same instruction suppresses training.
   assign train = ex_valid & ex_branch & ~ex_jump & ~ex_jalr;

   always_comb begin
      taken = 1'b0;
      case (ex_branch_type)
         3'b000:  taken = ex_zero;
         3'b001:  taken = ~ex_zero;
         3'b100:  taken = ex_slt;
         3'b101:  taken = ~ex_slt;
         3'b110:  taken = ex_sltu;
         3'b111:  taken = ~ex_sltu;
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      pc_src = 2'b00;
      flush  = 1'b0;
      if (ex_valid) begin
         if (ex_jalr) begin
            pc_src = 2'b10;
            flush  = 1'b1;
         end else if (ex_jump) begin
            pc_src = 2'b01;
            flush  = 1'b1;
         end else if (ex_branch && taken && !ex_pred_taken) begin
            pc_src = 2'b01;
            flush  = 1'b1;
         end else if (ex_branch && !taken && ex_pred_taken) begin
            pc_src = 2'b11;
            flush  = 1'b1;
         end
      end
   end

   always_comb begin
      bht_d = bht_q;
      if (train) begin
         if (taken && bht_q[ex_idx] != 2'b11) begin
            bht_d[ex_idx] = bht_q[ex_idx] + 2'b01;
         end else if (!taken && bht_q[ex_idx] != 2'b00) begin
            bht_d[ex_idx] = bht_q[ex_idx] - 2'b01;
         end
      end
   end

   // Counters reset to weakly not-taken.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < BHT_ENTRIES; i++) begin
            bht_q[i] <= 2'b01;
         end
      end else begin
         bht_q <= bht_d;
      end
   end

`ifdef PERF_CNT_EN
   logic [31:0] branch_count_q;
   logic [31:0] branch_count_d;
   logic [31:0] mispredict_count_q;
   logic [31:0] mispredict_count_d;
   logic        mispredict;

   // Only conditional-branch flushes count as mispredictions.
   assign mispredict = train & (taken ^ ex_pred_taken);

   always_comb begin
      branch_count_d     = branch_count_q + {31'd0, train};
      mispredict_count_d = mispredict_count_q + {31'd0, mispredict};
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         branch_count_q     <= '0;
         mispredict_count_q <= '0;
      end else begin
         branch_count_q     <= branch_count_d;
         mispredict_count_q <= mispredict_count_d;
      end
   end

   assign branch_count     = branch_count_q;
   assign mispredict_count = mispredict_count_q;
`else
   assign branch_count     = '0;
   assign mispredict_count = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_predict.sv
// Directed self-checking bench for branch_resolve_predict (64-entry main instance, 4-entry instance for aliasing).
module tb_branch_resolve_predict;

   logic        clk;
   logic        rst;
   logic [31:0] id_pc;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic        ex_branch;
   logic        ex_jump;
   logic        ex_jalr;
   logic [2:0]  ex_branch_type;
   logic        ex_zero;
   logic        ex_slt;
   logic        ex_sltu;
   logic        ex_pred_taken;

   logic        id_pred_taken;
   logic [1:0]  pc_src;
   logic        flush;
   logic [31:0] branch_count;
   logic [31:0] mispredict_count;

   logic        id_pred_taken4;
   logic [1:0]  pc_src4;
   logic        flush4;
   logic [31:0] branch_count4;
   logic [31:0] mispredict_count4;

   int checks;
   int failures;

   branch_resolve_predict #(.XLEN(32), .BHT_ENTRIES(64), .INDEX_LSB(2)) dut (
      .clk(clk), .rst(rst), .id_pc(id_pc), .id_pred_taken(id_pred_taken),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_branch(ex_branch), .ex_jump(ex_jump),
      .ex_jalr(ex_jalr), .ex_branch_type(ex_branch_type), .ex_zero(ex_zero),
      .ex_slt(ex_slt), .ex_sltu(ex_sltu), .ex_pred_taken(ex_pred_taken),
      .pc_src(pc_src), .flush(flush), .branch_count(branch_count),
      .mispredict_count(mispredict_count)
   );

   branch_resolve_predict #(.XLEN(32), .BHT_ENTRIES(4), .INDEX_LSB(2)) dut4 (
      .clk(clk), .rst(rst), .id_pc(id_pc), .id_pred_taken(id_pred_taken4),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_branch(ex_branch), .ex_jump(ex_jump),
      .ex_jalr(ex_jalr), .ex_branch_type(ex_branch_type), .ex_zero(ex_zero),
      .ex_slt(ex_slt), .ex_sltu(ex_sltu), .ex_pred_taken(ex_pred_taken),
      .pc_src(pc_src4), .flush(flush4), .branch_count(branch_count4),
      .mispredict_count(mispredict_count4)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Driver tasks: inputs change 1 time unit after the rising edge, outputs are read 1 unit later.
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ex();
      ex_valid = 0; ex_pc = '0; ex_branch = 0; ex_jump = 0; ex_jalr = 0;
      ex_branch_type = 3'b000; ex_zero = 0; ex_slt = 0; ex_sltu = 0; ex_pred_taken = 0;
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic br, input logic jmp,
                        input logic jr, input logic [2:0] ty, input logic z, input logic s,
                        input logic su, input logic p);
      ex_valid = v; ex_pc = pc; ex_branch = br; ex_jump = jmp; ex_jalr = jr;
      ex_branch_type = ty; ex_zero = z; ex_slt = s; ex_sltu = su; ex_pred_taken = p;
      #1;
   endtask

   task automatic do_reset();
      clear_ex();
      rst = 1'b0;
      cycle();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      id_pc = 32'h100;
      #1;
      checks++;
      if (id_pred_taken !== 1'b0) begin
         failures++; $display("FAIL reset_pred actual=%b expected=0", id_pred_taken);
      end
      checks++;
      if (branch_count !== 32'd0) begin
         failures++; $display("FAIL reset_branch_count actual=%0d expected=0", branch_count);
      end
      checks++;
      if (mispredict_count !== 32'd0) begin
         failures++; $display("FAIL reset_mispredict_count actual=%0d expected=0", mispredict_count);
      end
      checks++;
      if (pc_src !== 2'b00 || flush !== 1'b0) begin
         failures++; $display("FAIL reset_idle actual=%b/%b expected=00/0", pc_src, flush);
      end
   endtask

   task automatic test_beq_taken();
      do_reset();
      id_pc = 32'h100;
      drive(1, 32'h100, 1, 0, 0, 3'b000, 1, 0, 0, 0);
      checks++;
      if (pc_src !== 2'b01 || flush !== 1'b1) begin
         failures++; $display("FAIL beq_resolve actual=%b/%b expected=01/1", pc_src, flush);
      end
      checks++;
      if (id_pred_taken !== 1'b0) begin
         failures++; $display("FAIL beq_no_bypass actual=%b expected=0", id_pred_taken);
      end
      cycle();
      clear_ex();
      #1;
      checks++;
      if (id_pred_taken !== 1'b1) begin
         failures++; $display("FAIL beq_trained actual=%b expected=1", id_pred_taken);
      end
   endtask

   task automatic test_saturation();
      do_reset();
      id_pc = 32'h40;
      for (int i = 0; i < 5; i++) begin
         drive(1, 32'h40, 1, 0, 0, 3'b110, 0, 0, 1, (i > 0));
         checks++;
         if (id_pred_taken !== (i > 0)) begin
            failures++; $display("FAIL sat_pred_%0d actual=%b expected=%b", i, id_pred_taken, (i > 0));
         end
         checks++;
         if (pc_src !== ((i == 0) ? 2'b01 : 2'b00)) begin
            failures++; $display("FAIL sat_pc_src_%0d actual=%b expected=%b", i, pc_src,
                                 ((i == 0) ? 2'b01 : 2'b00));
         end
         cycle();
      end
      drive(1, 32'h40, 1, 0, 0, 3'b111, 0, 0, 1, 1);
      checks++;
      if (pc_src !== 2'b11 || flush !== 1'b1) begin
         failures++; $display("FAIL sat_bgeu_recover actual=%b/%b expected=11/1", pc_src, flush);
      end
      cycle();
      clear_ex();
      #1;
      checks++;
      if (id_pred_taken !== 1'b1) begin
         failures++; $display("FAIL sat_after_one_down actual=%b expected=1", id_pred_taken);
      end
      drive(1, 32'h40, 1, 0, 0, 3'b111, 0, 0, 1, 1);
      cycle();
      clear_ex();
      #1;
      checks++;
      if (id_pred_taken !== 1'b0) begin
         failures++; $display("FAIL sat_after_two_down actual=%b expected=0", id_pred_taken);
      end
   endtask

   task automatic test_branch_types();
      // {funct3, zero, slt, sltu, taken}
      logic [6:0] tbl [14];
      tbl = '{ {3'b000, 1'b1, 1'b0, 1'b0, 1'b1}, {3'b000, 1'b0, 1'b1, 1'b1, 1'b0},
               {3'b001, 1'b0, 1'b0, 1'b0, 1'b1}, {3'b001, 1'b1, 1'b1, 1'b1, 1'b0},
               {3'b100, 1'b0, 1'b1, 1'b0, 1'b1}, {3'b100, 1'b1, 1'b0, 1'b1, 1'b0},
               {3'b101, 1'b1, 1'b0, 1'b1, 1'b1}, {3'b101, 1'b0, 1'b1, 1'b0, 1'b0},
               {3'b110, 1'b0, 1'b0, 1'b1, 1'b1}, {3'b110, 1'b1, 1'b1, 1'b0, 1'b0},
               {3'b111, 1'b1, 1'b1, 1'b0, 1'b1}, {3'b111, 1'b0, 1'b0, 1'b1, 1'b0},
               {3'b010, 1'b1, 1'b1, 1'b1, 1'b0}, {3'b011, 1'b0, 1'b0, 1'b0, 1'b0} };
      do_reset();
      for (int i = 0; i < 14; i++) begin
         drive(1, 32'h0C, 1, 0, 0, tbl[i][6:4], tbl[i][3], tbl[i][2], tbl[i][1], 0);
         checks++;
         if (pc_src !== (tbl[i][0] ? 2'b01 : 2'b00) || flush !== tbl[i][0]) begin
            failures++; $display("FAIL type_row_%0d actual=%b/%b expected=%b/%b", i, pc_src, flush,
                                 (tbl[i][0] ? 2'b01 : 2'b00), tbl[i][0]);
         end
         cycle();
      end
      id_pc = 32'h88;
      drive(1, 32'h88, 1, 0, 0, 3'b000, 1, 0, 0, 0);
      cycle();
      drive(1, 32'h88, 1, 0, 0, 3'b010, 1, 1, 1, 1);
      checks++;
      if (id_pred_taken !== 1'b1 || pc_src !== 2'b11) begin
         failures++; $display("FAIL type_010_resolve actual=%b/%b expected=1/11", id_pred_taken, pc_src);
      end
      cycle();
      clear_ex();
      #1;
      checks++;
      if (id_pred_taken !== 1'b0) begin
         failures++; $display("FAIL type_010_trains_nt actual=%b expected=0", id_pred_taken);
      end
   endtask

   task automatic test_priority_and_bubble();
      do_reset();
      id_pc = 32'h60;
      drive(1, 32'h60, 1, 0, 1, 3'b000, 1, 0, 0, 0);
      checks++;
      if (pc_src !== 2'b10 || flush !== 1'b1) begin
         failures++; $display("FAIL jalr_branch actual=%b/%b expected=10/1", pc_src, flush);
      end
      cycle();
      drive(1, 32'h60, 1, 1, 0, 3'b000, 1, 0, 0, 1);
      checks++;
      if (pc_src !== 2'b01 || flush !== 1'b1) begin
         failures++; $display("FAIL jal_branch actual=%b/%b expected=01/1", pc_src, flush);
      end
      cycle();
      drive(0, 32'h60, 0, 0, 1, 3'b000, 0, 0, 0, 0);
      checks++;
      if (pc_src !== 2'b00 || flush !== 1'b0) begin
         failures++; $display("FAIL bubble_jalr actual=%b/%b expected=00/0", pc_src, flush);
      end
      cycle();
      drive(0, 32'h60, 1, 0, 0, 3'b000, 1, 0, 0, 0);
      checks++;
      if (pc_src !== 2'b00 || flush !== 1'b0) begin
         failures++; $display("FAIL bubble_branch actual=%b/%b expected=00/0", pc_src, flush);
      end
      cycle();
      clear_ex();
      #1;
      checks++;
      if (id_pred_taken !== 1'b0) begin
         failures++; $display("FAIL no_train_jump_bubble actual=%b expected=0", id_pred_taken);
      end
   endtask

   task automatic test_reset_midstream();
      do_reset();
      id_pc = 32'h60;
      rst = 1'b0;
      drive(1, 32'h60, 1, 0, 0, 3'b000, 1, 0, 0, 0);
      cycle();
      rst = 1'b1;
      clear_ex();
      #1;
      checks++;
      if (id_pred_taken !== 1'b0) begin
         failures++; $display("FAIL reset_discards_train actual=%b expected=0", id_pred_taken);
      end
   endtask

   task automatic test_aliasing();
      do_reset();
      id_pc = 32'h20;
      for (int i = 0; i < 2; i++) begin
         drive(1, 32'h10, 1, 0, 0, 3'b000, 1, 0, 0, 0);
         cycle();
      end
      clear_ex();
      #1;
      checks++;
      if (id_pred_taken4 !== 1'b1) begin
         failures++; $display("FAIL alias_4entry actual=%b expected=1", id_pred_taken4);
      end
      checks++;
      if (id_pred_taken !== 1'b0) begin
         failures++; $display("FAIL alias_64entry_distinct actual=%b expected=0", id_pred_taken);
      end
   endtask

   task automatic test_perf_counters();
      // {taken, predicted}: three mispredictions among ten branches
      logic [1:0] seq [10];
      logic [31:0] exp_br;
      logic [31:0] exp_mis;
      seq = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b11, 2'b10, 2'b00, 2'b11, 2'b00, 2'b11};
`ifdef PERF_CNT_EN
      exp_br = 32'd10; exp_mis = 32'd3;
`else
      exp_br = 32'd0;  exp_mis = 32'd0;
`endif
      do_reset();
      for (int i = 0; i < 10; i++) begin
         drive(1, 32'h80, 1, 0, 0, 3'b000, seq[i][1], 0, 0, seq[i][0]);
         checks++;
         if (flush !== (seq[i][1] ^ seq[i][0])) begin
            failures++; $display("FAIL perf_flush_%0d actual=%b expected=%b", i, flush,
                                 (seq[i][1] ^ seq[i][0]));
         end
         cycle();
      end
      for (int i = 0; i < 2; i++) begin
         drive(1, 32'h84, 0, 1, 0, 3'b000, 0, 0, 0, 0);
         cycle();
      end
      drive(0, 32'h80, 1, 0, 0, 3'b000, 1, 0, 0, 0);
      cycle();
      drive(1, 32'h80, 1, 0, 1, 3'b000, 1, 0, 0, 0);
      cycle();
      clear_ex();
      #1;
      checks++;
      if (branch_count !== exp_br) begin
         failures++; $display("FAIL perf_branch_count actual=%0d expected=%0d", branch_count, exp_br);
      end
      checks++;
      if (mispredict_count !== exp_mis) begin
         failures++; $display("FAIL perf_mispredict_count actual=%0d expected=%0d", mispredict_count, exp_mis);
      end
      do_reset();
      #1;
      checks++;
      if (branch_count !== 32'd0 || mispredict_count !== 32'd0) begin
         failures++; $display("FAIL perf_reset actual=%0d/%0d expected=0/0", branch_count, mispredict_count);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      id_pc    = '0;
      clear_ex();
      test_reset();
      test_beq_taken();
      test_saturation();
      test_branch_types();
      test_priority_and_bubble();
      test_reset_midstream();
      test_aliasing();
      test_perf_counters();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/branch_resolve_predict.md
# branch_resolve_predict

Parametrised branch resolution unit with a branch history table (BHT) of 2-bit saturating counters. It supersedes the purely combinational PC-source calculation.
- ID side: looks up a taken/not-taken prediction for the branch being decoded, so ID can redirect early.
- EX side: resolves all six RISC-V conditional branches plus JAL/JALR, selects the PC source and raises a flush on misprediction.
- Trains the BHT with each resolved branch.

## Interface
Parameters:
- XLEN, 32: PC width.
- BHT_ENTRIES, 64: counter count; power of two, ≥ 2. IDX_W = log2(BHT_ENTRIES).
- INDEX_LSB, 2: lowest PC bit used for the BHT index.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset: one clock; reset is synchronous and active-low.
- id_pc  in  XLEN  PC of the instruction in ID.
- id_pred_taken  out  1  prediction for id_pc; combinational, equals bit 1 of the counter at id_pc[INDEX_LSB +: IDX_W].
- ex_valid  in  1  EX holds a real (non-bubble) instruction.
- ex_pc  in  XLEN  PC of the EX instruction.
- ex_branch  in  1  conditional branch.
- ex_jump  in  1  JAL.
- ex_jalr  in  1  JALR.
- ex_branch_type  in  3  funct3: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
- ex_zero, ex_slt, ex_sltu  in  1 each  ALU flags: equal, signed less-than, unsigned less-than.
- ex_pred_taken  in  1  id_pred_taken value piped down with this instruction.
- pc_src  out  2  00 PC+4, 01 branch/JAL target, 10 JALR target, 11 recover to ex_pc+4.
- flush  out  1  kill IF and ID this cycle.
- branch_count, mispredict_count  out  32 each  performance counters.

## Operation
Branch condition (taken):
- BEQ: ex_zero. BNE: !ex_zero.
- BLT: ex_slt. BGE: !ex_slt.
- BLTU: ex_sltu. BGEU: !ex_sltu.
- 010/011: never taken; the BHT is still trained as not-taken.

Resolution is combinational from the EX inputs. Priority is top-down:
- ex_valid=0: pc_src=00, flush=0, no training.
- ex_jalr: pc_src=10, flush=1.
- ex_jump: pc_src=01, flush=1.
- ex_branch, taken, ex_pred_taken=0: pc_src=01, flush=1.
- ex_branch, not taken, ex_pred_taken=1: pc_src=11, flush=1.
- Otherwise: pc_src=00, flush=0.

Simultaneous flags: if more than one of ex_jalr/ex_jump/ex_branch is set, priority decides pc_src. The BHT trains only when ex_branch=1 and ex_jalr=ex_jump=0.

Training:
- Condition: ex_valid & ex_branch (subject to the rule above).
- Counter at ex_pc[INDEX_LSB +: IDX_W] saturates up when taken, down when not taken.
- Range 00..11: 11+taken stays 11; 00+not-taken stays 00.

## Timing
- Prediction: zero-cycle combinational lookup.
- Training: written on the clock edge at the end of the EX cycle; visible to id_pc lookups from the next cycle.
- Same-cycle read/write of the same index: id_pred_taken returns the pre-update value. There is no bypass.
- pc_src and flush have zero-cycle latency from the EX inputs.
- Reset (rst=0 at an edge):
  - Every counter goes to 01 (weakly not-taken).
  - Perf counters go to 0.
  - Reset mid-stream discards any training pending that cycle.
  - pc_src and flush stay combinational during reset. The pipeline ignores them while rst=0.
- Index uses only the stated PC bits; aliasing PCs share a counter.

## Configuration
PERF_CNT_EN:
- Defined: on each trained branch, branch_count increments. mispredict_count increments whenever flush=1 due to a conditional branch; JAL/JALR flushes are not counted. Both wrap modulo 2^32.
- Not defined: both outputs are tied to 0 and no counter registers exist.

## Test plan
- Reset then read: rst=0 for one edge, then any id_pc → id_pred_taken=0; branch_count=0.
- BEQ taken from reset, ex_zero=1, ex_pred_taken=0, ex_pc=0x100 → pc_src=01, flush=1. Counter 01→10; next cycle id_pc=0x100 gives id_pred_taken=1.
- Saturation:
  - Four taken BLTU at 0x40 (ex_sltu=1) → counter 11; a fifth keeps 11.
  - One BGEU not-taken with ex_pred_taken=1 → pc_src=11, flush=1, counter 10.
- Aliasing: BHT_ENTRIES=4; train 0x10 taken twice → id_pc=0x20 (same index) gives id_pred_taken=1.
- JALR with ex_branch=1 also set → pc_src=10, flush=1, counter unchanged. Bubble (ex_valid=0, ex_jalr=1) → pc_src=00, flush=0.
- PERF_CNT_EN defined: 10 branches with 3 mispredicts plus 2 JALs → branch_count=10, mispredict_count=3. Undefined → both 0.
